// File: rtl/sbox_arbiter.sv
// sbox_arbiter
//   Two-port arbiter in front of the shared byte-wide S-box ROM.
//   Port 0 serves key expansion (SubWord), port 1 the round datapath
//   (SubBytes). One lookup is issued per cycle. Round-robin arbitration
//   applies unless a port holds ownership through its lock input. A
//   ROM_LAT-deep tag pipeline steers each ROM result back to the port that
//   issued the lookup.
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     req0/1, lock0/1     lookup request, keep ownership after this grant
//     addr0/1             S-box address, held stable while req is high
//     gnt0/1              request accepted this cycle (combinational)
//     rvalid0/1, rdata0/1 result pulse and data, ROM_LAT cycles after gnt
//     rom_addr/ce/re      drive to sbox_rom (combinational with gnt)
//     rom_data            sbox_rom read data
//     gcnt0/1             per-port grant counters
//
//   Optional feature: define SBOX_ARB_STATS_EN to get saturating grant
//   counters on gcnt0/gcnt1. Without it those ports are tied to zero.
module sbox_arbiter #(
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [7:0]       addr0,
  input  logic [7:0]       addr1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [7:0]       rdata0,
  output logic [7:0]       rdata1,
  output logic [7:0]       rom_addr,
  output logic             rom_ce,
  output logic             rom_re,
  input  logic [7:0]       rom_data,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1
);

  typedef enum logic [1:0] {
    ST_RR   = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;   // port granted most recently

  logic               gnt_any;
  logic [ROM_LAT-1:0] vld_q;
  logic [ROM_LAT-1:0] prt_q;
  logic               vld_end;
  logic               prt_end;
  logic [7:0]         rdata0_q;
  logic [7:0]         rdata1_q;

  // ---------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RR;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RR: begin
          if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        ST_OWN0: gnt0 = req0;
        ST_OWN1: gnt1 = req1;
        default: ;
      endcase

      if (gnt0) begin
        last_d  = 1'b0;
        state_d = lock0 ? ST_OWN0 : ST_RR;
      end else if (gnt1) begin
        last_d  = 1'b1;
        state_d = lock1 ? ST_OWN1 : ST_RR;
      end else if ((state_q == ST_OWN0 && !req0) ||
                   (state_q == ST_OWN1 && !req1)) begin
        // Owner abandoned its burst: release to round-robin.
        state_d = ST_RR;
      end
    end
  end

  // ---------------------------------------------------------------------
  // ROM drive
  // ---------------------------------------------------------------------
  assign gnt_any  = gnt0 | gnt1;
  assign rom_ce   = gnt_any;
  assign rom_re   = gnt_any;
  assign rom_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);

  // ---------------------------------------------------------------------
  // Return path: {valid, port} tag travels alongside the ROM read
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      prt_q <= '0;
    end else begin
      // Truncating cast shifts in at bit 0. It also covers ROM_LAT == 1.
      vld_q <= ROM_LAT'({vld_q, gnt_any});
      prt_q <= ROM_LAT'({prt_q, gnt1});
    end
  end

  assign vld_end = vld_q[ROM_LAT-1];
  assign prt_end = prt_q[ROM_LAT-1];
  assign rvalid0 = vld_end & ~prt_end;
  assign rvalid1 = vld_end & prt_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= rom_data;
      if (rvalid1) rdata1_q <= rom_data;
    end
  end

  // The result is presented in its rvalid cycle straight from the ROM. The
  // register then holds it until that port's next return.
  assign rdata0 = rvalid0 ? rom_data : rdata0_q;
  assign rdata1 = rvalid1 ? rom_data : rdata1_q;

  // ---------------------------------------------------------------------
  // Grant counters
  // ---------------------------------------------------------------------
`ifdef SBOX_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt0_q, gcnt0_d;
  logic [CNT_W-1:0] gcnt1_q, gcnt1_d;

  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    if (gnt0 && gcnt0_q != '1) gcnt0_d = gcnt0_q + CNT_W'(1);
    if (gnt1 && gcnt1_q != '1) gcnt1_d = gcnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`else
  assign gcnt0 = '0;
  assign gcnt1 = '0;
`endif

endmodule

// File: tb/tb_sbox_arbiter.sv
module tb_sbox_arbiter;
  localparam int unsigned L  = 2;
  localparam int unsigned CW = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [7:0]    addr0 = 8'h00, addr1 = 8'h00;
  logic          gnt0, gnt1, rvalid0, rvalid1, rom_ce, rom_re;
  logic [7:0]    rdata0, rdata1, rom_addr, rom_data;
  logic [CW-1:0] gcnt0, gcnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbox_arbiter #(.ROM_LAT(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_re(rom_re),
    .rom_data(rom_data),
    .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  // AES S-box computed from its definition: GF(2^8) inverse plus affine map.
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // ROM model: address registered, data available L cycles after issue.
  logic [7:0] rpipe [L];
  always @(posedge clk) begin
    rpipe[0] <= rom_addr;
    for (int k = 1; k < int'(L); k++) rpipe[k] <= rpipe[k-1];
  end
  assign rom_data = sbox_t[rpipe[L-1]];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: owner/last-grant rules, a queue of pending returns
  // ---------------------------------------------------------------------
  typedef struct {
    int         due;
    int         port;
    logic [7:0] data;
  } ret_t;

  ret_t       q[$];
  int         cyc = 0;
  int         owner = -1;
  int         mlast = 1;
  logic [7:0] exp_rd0 = 8'h00, exp_rd1 = 8'h00;
  int         gcount0 = 0, gcount1 = 0;
  logic       eg0 = 1'b0, eg1 = 1'b0;

  always @(negedge clk) begin
    ret_t       r;
    logic       ev0, ev1;
    logic [7:0] ea;
    int         xg0, xg1;
    cyc++;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (rst) begin
      owner = -1; mlast = 1; q.delete();
      exp_rd0 = 8'h00; exp_rd1 = 8'h00;
      gcount0 = 0; gcount1 = 0;
    end else if (owner == 0) begin
      eg0 = req0;
    end else if (owner == 1) begin
      eg1 = req1;
    end else if (req0 && req1) begin
      if (mlast == 1) eg0 = 1'b1; else eg1 = 1'b1;
    end else begin
      eg0 = req0;
      eg1 = req1;
    end

    ea = eg0 ? addr0 : (eg1 ? addr1 : 8'h00);
    chk("gnt0", int'(gnt0), int'(eg0));
    chk("gnt1", int'(gnt1), int'(eg1));
    chk("rom_ce", int'(rom_ce), int'(eg0 | eg1));
    chk("rom_re", int'(rom_re), int'(eg0 | eg1));
    chk("rom_addr", int'(rom_addr), int'(ea));

    ev0 = 1'b0;
    ev1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.port == 0) begin ev0 = 1'b1; exp_rd0 = r.data; end
      else             begin ev1 = 1'b1; exp_rd1 = r.data; end
    end
    chk("rvalid0", int'(rvalid0), int'(ev0));
    chk("rvalid1", int'(rvalid1), int'(ev1));
    chk("rdata0", int'(rdata0), int'(exp_rd0));
    chk("rdata1", int'(rdata1), int'(exp_rd1));

`ifdef SBOX_ARB_STATS_EN
    xg0 = gcount0; xg1 = gcount1;
`else
    xg0 = 0; xg1 = 0;
`endif
    chk("gcnt0", int'(gcnt0), xg0);
    chk("gcnt1", int'(gcnt1), xg1);

    if (eg0) begin
      q.push_back('{due: cyc + int'(L), port: 0, data: sbox_t[addr0]});
      mlast = 0;
      owner = lock0 ? 0 : -1;
      if (gcount0 < CMAX) gcount0++;
    end else if (eg1) begin
      q.push_back('{due: cyc + int'(L), port: 1, data: sbox_t[addr1]});
      mlast = 1;
      owner = lock1 ? 1 : -1;
      if (gcount1 < CMAX) gcount1++;
    end else if ((owner == 0 && !req0) || (owner == 1 && !req1)) begin
      owner = -1;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus with hand-computed expectations
  // ---------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_f(8'(i));

    // Reset with a request held: it must be ignored.
    rst = 1'b1; req0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt0", int'(gnt0), 0);
    chk("rst_rdata0", int'(rdata0), 0);

    // 1: lone request at 8'h00 right after release.
    nxt(); rst = 1'b0; req0 = 1'b1; addr0 = 8'h00;
    @(negedge clk);
    chk("t1_gnt0", int'(gnt0), 1);
    nxt(); req0 = 1'b0;
    repeat (L) @(negedge clk);
    chk("t1_rvalid0", int'(rvalid0), 1);
    chk("t1_rdata0", int'(rdata0), 8'h63);
    chk("t1_rvalid1", int'(rvalid1), 0);

    // 2: both ports every cycle. Port 0 won last, so port 1 goes first.
    nxt(); req0 = 1'b1; req1 = 1'b1; addr0 = 8'h01; addr1 = 8'h53;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_gnt0", int'(gnt0), i % 2);
      chk("t2_gnt1", int'(gnt1), 1 - (i % 2));
    end
    nxt(); req0 = 1'b0; req1 = 1'b0;
    repeat (L + 1) @(negedge clk);
    chk("t2_rdata0", int'(rdata0), 8'h7C);
    chk("t2_rdata1", int'(rdata1), 8'hED);

    // 3: locked burst on port 0 while port 1 waits.
    for (int i = 0; i < 5; i++) begin
      nxt(); req0 = (i < 4); lock0 = (i < 3); req1 = (i >= 1);
      @(negedge clk);
      chk("t3_gnt0", int'(gnt0), (i < 4) ? 1 : 0);
      chk("t3_gnt1", int'(gnt1), (i == 4) ? 1 : 0);
    end
    nxt(); req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;

    // 4: locked owner 1 abandons; pending port 0 wins the following cycle.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 8'h20;
    @(negedge clk);
    chk("t4_gnt1", int'(gnt1), 1);
    nxt(); req1 = 1'b0; req0 = 1'b1; addr0 = 8'h30;
    @(negedge clk);
    chk("t4_stall", int'(gnt0), 0);
    @(negedge clk);
    chk("t4_gnt0", int'(gnt0), 1);
    nxt(); req0 = 1'b0; lock1 = 1'b0;
    repeat (L + 2) nxt();

    // 5: reset while a lookup is in flight.
    req0 = 1'b1; addr0 = 8'h10;
    @(negedge clk);
    chk("t5_gnt0", int'(gnt0), 1);
    nxt(); rst = 1'b1; req0 = 1'b0;
    nxt();
    nxt(); rst = 1'b0;
    for (int i = 0; i < int'(L) + 2; i++) begin
      @(negedge clk);
      chk("t5_rvalid0", int'(rvalid0), 0);
      chk("t5_rdata0", int'(rdata0), 0);
    end
    chk("t5_gcnt0", int'(gcnt0), 0);

    // 6: 20 grants to port 0 saturate a 4-bit counter.
    nxt(); req0 = 1'b1; addr0 = 8'h05;
    repeat (20) nxt();
    req0 = 1'b0;
    @(negedge clk);
`ifdef SBOX_ARB_STATS_EN
    chk("t6_gcnt0", int'(gcnt0), 15);
`else
    chk("t6_gcnt0", int'(gcnt0), 0);
`endif

    // Random traffic with legal handshakes and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      nxt();
      rst = ($urandom_range(0, 199) == 0);
      if (req0 && !eg0) begin
        if ($urandom_range(0, 7) == 0) req0 = 1'b0;
      end else begin
        req0  = ($urandom_range(0, 2) != 0);
        addr0 = 8'($urandom);
      end
      if (req1 && !eg1) begin
        if ($urandom_range(0, 7) == 0) req1 = 1'b0;
      end else begin
        req1  = ($urandom_range(0, 2) != 0);
        addr1 = 8'($urandom);
      end
      lock0 = ($urandom_range(0, 2) == 0);
      lock1 = ($urandom_range(0, 2) == 0);
    end

    nxt(); rst = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    repeat (L + 4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
